// File: rtl/unary_pkg.sv
// Shared types and constants for the unary stream encoder.
package unary_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } enc_state_t;

    localparam int ORDER_THERMO = 0;
    localparam int ORDER_SPREAD = 1;

endpackage

// File: rtl/unary_stream_encoder.sv
// Serialises one binary operand into an N-bit unary bitstream, one bit per clock.
// Latency: first bit registered one edge after the handshake, N bits per stream, one bubble between streams.
// Backpressure: in_ready only in IDLE; hold freezes the stream (bit_valid low, counters and bit_out frozen).
module unary_stream_encoder
    import unary_pkg::*;
#(
    parameter int INPUT_WIDTH = 32,
    parameter int COUNT_WIDTH = $clog2(INPUT_WIDTH + 1),
    parameter int ORDER       = ORDER_SPREAD
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [COUNT_WIDTH-1:0] in_value,
    input  logic                   hold,
    output logic                   bit_out,
    output logic                   bit_valid,
    output logic                   last
);

    localparam logic [COUNT_WIDTH-1:0] N_CNT    = COUNT_WIDTH'(INPUT_WIDTH);
    localparam logic [COUNT_WIDTH-1:0] LAST_CNT = COUNT_WIDTH'(INPUT_WIDTH - 1);
    localparam logic [COUNT_WIDTH:0]   N_ACC    = (COUNT_WIDTH + 1)'(INPUT_WIDTH);
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);

    enc_state_t             state, state_nxt;
    logic [COUNT_WIDTH-1:0] count, count_nxt;
    logic [COUNT_WIDTH-1:0] ones, ones_nxt;
    logic [COUNT_WIDTH-1:0] value, value_nxt;
    logic [COUNT_WIDTH:0]   acc, acc_nxt;
    logic                   bit_out_nxt;
    logic                   bit_valid_nxt;
    logic                   last_nxt;

    logic [COUNT_WIDTH-1:0] in_sat;
    logic [COUNT_WIDTH:0]   acc_sum;
    logic [COUNT_WIDTH:0]   acc_wrap;
    logic                   spread_bit;
    logic                   thermo_bit;
    logic                   stream_bit;

    // acc < N and value <= N, so the sum never exceeds 2N-1 and fits in COUNT_WIDTH+1 bits.
    always_comb begin
        in_sat     = (in_value > N_CNT) ? N_CNT : in_value;
        acc_sum    = acc + {1'b0, value};
        spread_bit = (acc_sum >= N_ACC);
        acc_wrap   = spread_bit ? (acc_sum - N_ACC) : acc_sum;
        thermo_bit = (count < value);
        stream_bit = (ORDER == ORDER_THERMO) ? thermo_bit : spread_bit;
    end

    assign in_ready = (state == IDLE);

    always_comb begin
        state_nxt     = state;
        count_nxt     = count;
        ones_nxt      = ones;
        value_nxt     = value;
        acc_nxt       = acc;
        bit_out_nxt   = bit_out;
        bit_valid_nxt = 1'b0;
        last_nxt      = 1'b0;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    value_nxt = in_sat;
                    count_nxt = '0;
                    ones_nxt  = '0;
                    acc_nxt   = '0;
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (!hold) begin
                    bit_out_nxt   = stream_bit;
                    bit_valid_nxt = 1'b1;
                    count_nxt     = count + CNT_ONE;
                    acc_nxt       = acc_wrap;
                    if (stream_bit) begin
                        ones_nxt = ones + CNT_ONE;
                    end
                    if (count == LAST_CNT) begin
                        last_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            count     <= '0;
            ones      <= '0;
            value     <= '0;
            acc       <= '0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            last      <= 1'b0;
        end else begin
            state     <= state_nxt;
            count     <= count_nxt;
            ones      <= ones_nxt;
            value     <= value_nxt;
            acc       <= acc_nxt;
            bit_out   <= bit_out_nxt;
            bit_valid <= bit_valid_nxt;
            last      <= last_nxt;
        end
    end

endmodule

// File: tb/tb_unary_stream_encoder.sv
// Bench: thermometer and spread encoders driven in lockstep and compared against an arithmetic model.
module tb_unary_stream_encoder;
    import unary_pkg::*;

    localparam int N  = 32;
    localparam int CW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          hold = 1'b0;
    logic [CW-1:0] in_value = '0;

    logic t_ready, t_bit, t_bv, t_last;
    logic s_ready, s_bit, s_bv, s_last;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_hs = -1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    unary_stream_encoder #(.INPUT_WIDTH(N), .ORDER(ORDER_THERMO)) dut_thermo (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(t_ready),
        .in_value(in_value), .hold(hold), .bit_out(t_bit), .bit_valid(t_bv), .last(t_last)
    );

    unary_stream_encoder #(.INPUT_WIDTH(N), .ORDER(ORDER_SPREAD)) dut_spread (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_ready),
        .in_value(in_value), .hold(hold), .bit_out(s_bit), .bit_valid(s_bv), .last(s_last)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Bit k of the stream, straight from the definition of each ordering.
    function automatic int exp_bit(input int order, input int v, input int k);
        if (order == 0) return (k < v) ? 1 : 0;
        return (v * (k + 1)) / N - (v * k) / N;
    endfunction

    task automatic check_quiet(input string tag, input logic exp_ready);
        check({tag, "_t_valid"}, 32'(t_bv), 0);
        check({tag, "_s_valid"}, 32'(s_bv), 0);
        check({tag, "_t_last"}, 32'(t_last), 0);
        check({tag, "_s_last"}, 32'(s_last), 0);
        check({tag, "_t_ready"}, 32'(t_ready), 32'(exp_ready));
        check({tag, "_s_ready"}, 32'(s_ready), 32'(exp_ready));
    endtask

    // One operand through both encoders. Called and returns on a negedge.
    task automatic run_stream(input int v, input int hold_at, input int hold_len, input bit rnd_hold,
                              input bit keep_valid, input bit gap_check, input int abort_at);
        int   vs;
        int   k;
        int   held;
        int   guard;
        int   ones_t;
        int   ones_s;
        int   hs;
        logic prev_t, prev_s;
        logic h;
        vs = (v > N) ? N : v;
        k = 0; held = 0; ones_t = 0; ones_s = 0;

        guard = 0;
        while (!t_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("ready_before_hs", 32'(t_ready), 1);

        in_valid = 1'b1;
        in_value = CW'(v);
        hold = rnd_hold ? 1'($urandom_range(0, 1)) : 1'b0;
        @(posedge clk);
        #1;
        hs = cyc;
        if (gap_check) check("handshake_gap", 32'(hs - last_hs), N + 1);
        last_hs = hs;
        @(negedge clk);
        check_quiet("bubble", 1'b0);
        prev_t = t_bit;
        prev_s = s_bit;

        guard = 0;
        while (k < N && guard < 4 * N) begin
            guard++;
            h = (k == hold_at && held < hold_len) || (rnd_hold && k > 0 && $urandom_range(0, 4) == 0);
            if (k == hold_at && held < hold_len) held++;
            hold     = h;
            in_valid = keep_valid ? 1'b1 : 1'($urandom_range(0, 1));
            in_value = CW'($urandom_range(0, 63));
            @(negedge clk);
            if (h) begin
                check("hold_t_valid", 32'(t_bv), 0);
                check("hold_s_valid", 32'(s_bv), 0);
                check("hold_last", 32'(s_last), 0);
                check("hold_t_bit_kept", 32'(t_bit), 32'(prev_t));
                check("hold_s_bit_kept", 32'(s_bit), 32'(prev_s));
            end else begin
                check("t_valid", 32'(t_bv), 1);
                check("s_valid", 32'(s_bv), 1);
                check("t_bit", 32'(t_bit), exp_bit(0, vs, k));
                check("s_bit", 32'(s_bit), exp_bit(1, vs, k));
                check("t_last", 32'(t_last), (k == N - 1) ? 1 : 0);
                check("s_last", 32'(s_last), (k == N - 1) ? 1 : 0);
                ones_t += int'(t_bit);
                ones_s += int'(s_bit);
                prev_t = t_bit;
                prev_s = s_bit;
                k++;
            end
            check("t_ready_in_stream", 32'(t_ready), (k == N) ? 1 : 0);
            check("s_ready_in_stream", 32'(s_ready), (k == N) ? 1 : 0);
            if (k == abort_at) begin
                reset = 1'b0;
                #1;
                check("abort_t_bit", 32'(t_bit), 0);
                check("abort_s_bit", 32'(s_bit), 0);
                check_quiet("abort", 1'b1);
                @(negedge clk);
                reset    = 1'b1;
                in_valid = 1'b0;
                hold     = 1'b0;
                return;
            end
        end
        check("stream_len", 32'(k), N);
        hold = 1'b0;
        check("t_ones", 32'(ones_t), 32'(vs));
        check("s_ones", 32'(ones_s), 32'(vs));
        if (!keep_valid) begin
            in_valid = 1'b0;
            @(negedge clk);
            check_quiet("after_last", 1'b1);
        end
    endtask

    initial begin
        #1;
        check("rst_t_bit", 32'(t_bit), 0);
        check("rst_s_bit", 32'(s_bit), 0);
        check_quiet("rst", 1'b1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        run_stream(8,  -1, 0, 1'b0, 1'b0, 1'b0, -1);
        run_stream(5,  -1, 0, 1'b0, 1'b0, 1'b0, -1);
        run_stream(0,  -1, 0, 1'b0, 1'b0, 1'b0, -1);
        run_stream(32, -1, 0, 1'b0, 1'b0, 1'b0, -1);
        run_stream(40, -1, 0, 1'b0, 1'b0, 1'b0, -1);
        run_stream(12, 10, 3, 1'b0, 1'b0, 1'b0, -1);
        run_stream(20, 31, 2, 1'b0, 1'b0, 1'b0, -1);
        run_stream(7,  -1, 0, 1'b1, 1'b0, 1'b0, -1);

        run_stream(9,  -1, 0, 1'b0, 1'b1, 1'b0, -1);
        run_stream(17, -1, 0, 1'b0, 1'b1, 1'b1, -1);
        run_stream(3,  -1, 0, 1'b0, 1'b1, 1'b1, -1);
        in_valid = 1'b0;
        @(negedge clk);
        check_quiet("cont_end", 1'b1);

        run_stream(25, -1, 0, 1'b0, 1'b0, 1'b0, 17);
        run_stream(6,  -1, 0, 1'b0, 1'b0, 1'b0, -1);

        for (int i = 0; i < 8; i++) begin
            run_stream($urandom_range(0, 40), $urandom_range(1, 31), $urandom_range(0, 3),
                       1'b1, 1'b0, 1'b0, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
